pll_reset_sequencer: RTL



---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: state encoding,
// counter sizing and saturating event counters.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    REL_CORE  = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The counter never exceeds max_count-1, so clog2(max_count) bits suffice.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the local clock.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, filters LOCK and releases the core then peripheral
// resets in order; retries the PLL on lock timeout, re-resets on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_FILTER    = 1024,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STAGE_GAP      = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOCK,
  output logic       PLL_RST,
  output logic       RST_CORE,
  output logic       RST_PERIPH,
  output logic       READY,
  output logic [7:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT,
  output pll_state_e STATE_DBG
);

  localparam int MAX_CNT = max4(LOCK_FILTER, LOCK_TIMEOUT, PLL_RST_CYCLES, STAGE_GAP);
  localparam int CW      = cnt_width(MAX_CNT);

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

  pll_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          pll_rst_q;
  logic          rst_core_q;
  logic          rst_periph_q;
  logic          ready_q;
  logic [7:0]    retry_q;
  logic [7:0]    loss_q;
  logic          lock_s;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (LOCK),
    .q_o  (lock_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= PLL_RESET;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      ready_q      <= 1'b0;
      retry_q      <= 8'd0;
      loss_q       <= 8'd0;
    end else begin
      case (state_q)
        PLL_RESET: begin
          if (cnt_q == PLL_RST_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // A lock seen on the timeout cycle takes priority over the retry.
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= FILTER;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            retry_q   <= sat_inc8(retry_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FILTER: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == FILTER_LAST) begin
            state_q    <= REL_CORE;
            cnt_q      <= '0;
            rst_core_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        REL_CORE: begin
          if (!lock_s) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            rst_core_q   <= 1'b1;
            rst_periph_q <= 1'b1;
            ready_q      <= 1'b0;
            loss_q       <= sat_inc8(loss_q);
          end else if (cnt_q == GAP_LAST) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            rst_periph_q <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // The PLL relocks by itself after a loss; WAIT_LOCK's timeout covers failure.
        RUN: begin
          if (!lock_s) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            rst_core_q   <= 1'b1;
            rst_periph_q <= 1'b1;
            ready_q      <= 1'b0;
            loss_q       <= sat_inc8(loss_q);
          end
        end
        default: begin
          state_q      <= PLL_RESET;
          cnt_q        <= '0;
          pll_rst_q    <= 1'b1;
          rst_core_q   <= 1'b1;
          rst_periph_q <= 1'b1;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

  release_order_a : assert property (@(posedge CLK) disable iff (RST)
    !(rst_core_q && !rst_periph_q));

  assign PLL_RST    = pll_rst_q;
  assign RST_CORE   = rst_core_q;
  assign RST_PERIPH = rst_periph_q;
  assign READY      = ready_q;
  assign RETRY_CNT  = retry_q;
  assign LOSS_CNT   = loss_q;
  assign STATE_DBG  = state_q;

endmodule
